// File: rtl/rv_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control path.
// Select encodings match the datapath mux ordering.
package rv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4     = 2'd0,
        PC_ALU       = 2'd1,
        PC_ALU_ALIGN = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        A_RS1    = 2'd0,
        A_OLD_PC = 2'd1,
        A_ZERO   = 2'd2
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        return (opc == OPC_OP)     || (opc == OPC_OP_IMM) || (opc == OPC_LOAD)  ||
               (opc == OPC_STORE)  || (opc == OPC_BRANCH) || (opc == OPC_JAL)   ||
               (opc == OPC_JALR)   || (opc == OPC_LUI)    || (opc == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5].
// Everything other than OP / OP-IMM uses the adder (address and PC arithmetic).
module rv_alu_dec
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_e    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
            case (funct3)
                3'b000:  alu_op = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a sticky TRAP.
// Control outputs are combinational from state and the instruction register.
module rv_mc_ctrl
    import rv_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DATAWIDTH-1:0] instrcode_i,
    input  logic                 imem_ready_i,
    input  logic                 dmem_ready_i,
    input  logic                 branch_taken_i,
    output logic                 imem_req_o,
    output logic                 ir_we_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_sel_o,
    output logic [1:0]           alu_a_sel_o,
    output logic                 alu_b_sel_o,
    output logic [3:0]           alu_op_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic                 rf_we_o,
    output logic [1:0]           wb_sel_o,
    output logic                 illegal_o
);

    state_e     state_reg;
    state_e     state_next;
    logic [6:0] opcode;
    alu_op_e    dec_op;
    logic       unused_instr_bits;

    assign opcode            = instrcode_i[6:0];
    assign unused_instr_bits = ^{instrcode_i[DATAWIDTH-1:31], instrcode_i[29:15], instrcode_i[11:7]};

    rv_alu_dec u_alu_dec (
        .opcode   (opcode),
        .funct3   (instrcode_i[14:12]),
        .funct7_5 (instrcode_i[30]),
        .alu_op   (dec_op)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:  if (imem_ready_i) state_next = ST_DECODE;
            ST_DECODE: state_next = is_legal_opcode(opcode) ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                    state_next = ST_MEM;
                end else if (opcode == OPC_BRANCH) begin
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready_i) state_next = (opcode == OPC_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB:   state_next = ST_FETCH;
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_FETCH;
        endcase
    end

    // Gated by rst_ni so every output is 0 while reset is held, even though state reads FETCH.
    always_comb begin
        imem_req_o  = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = PC_PLUS4;
        alu_a_sel_o = A_RS1;
        alu_b_sel_o = 1'b0;
        alu_op_o    = ALU_ADD;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        rf_we_o     = 1'b0;
        wb_sel_o    = WB_ALU;
        illegal_o   = 1'b0;
        if (rst_ni) begin
            case (state_reg)
                ST_FETCH: begin
                    imem_req_o = 1'b1;
                    if (imem_ready_i) begin
                        ir_we_o = 1'b1;
                        pc_we_o = 1'b1;
                    end
                end
                ST_EXEC, ST_MEM: begin
                    // ALU selects held identical in MEM so the address stays stable.
                    alu_op_o = dec_op;
                    case (opcode)
                        OPC_OP:  alu_b_sel_o = 1'b0;
                        OPC_LUI: begin
                            alu_a_sel_o = A_ZERO;
                            alu_b_sel_o = 1'b1;
                        end
                        OPC_AUIPC, OPC_BRANCH, OPC_JAL: begin
                            alu_a_sel_o = A_OLD_PC;
                            alu_b_sel_o = 1'b1;
                        end
                        default: alu_b_sel_o = 1'b1;
                    endcase
                    if (state_reg == ST_EXEC) begin
                        if ((opcode == OPC_BRANCH && branch_taken_i) || opcode == OPC_JAL) begin
                            pc_we_o  = 1'b1;
                            pc_sel_o = PC_ALU;
                        end else if (opcode == OPC_JALR) begin
                            pc_we_o  = 1'b1;
                            pc_sel_o = PC_ALU_ALIGN;
                        end
                    end else begin
                        dmem_req_o = 1'b1;
                        dmem_we_o  = (opcode == OPC_STORE);
                    end
                end
                ST_WB: begin
                    rf_we_o = 1'b1;
                    if (opcode == OPC_LOAD) begin
                        wb_sel_o = WB_LOAD;
                    end else if (opcode == OPC_JAL || opcode == OPC_JALR) begin
                        wb_sel_o = WB_PC4;
                    end
                end
                ST_TRAP: illegal_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed self-checking bench for rv_mc_ctrl: per-cycle expected output vectors per instruction.
module tb_rv_mc_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] instrcode_i;
    logic        imem_ready_i;
    logic        dmem_ready_i;
    logic        branch_taken_i;
    logic        imem_req_o;
    logic        ir_we_o;
    logic        pc_we_o;
    logic [1:0]  pc_sel_o;
    logic [1:0]  alu_a_sel_o;
    logic        alu_b_sel_o;
    logic [3:0]  alu_op_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        rf_we_o;
    logic [1:0]  wb_sel_o;
    logic        illegal_o;

    int checks   = 0;
    int failures = 0;

    // Packed view: {imem_req, ir_we, pc_we, pc_sel[2], alu_a_sel[2], alu_b_sel, alu_op[4], dmem_req, dmem_we, rf_we, wb_sel[2], illegal}
    logic [17:0] obs;
    assign obs = {imem_req_o, ir_we_o, pc_we_o, pc_sel_o, alu_a_sel_o, alu_b_sel_o, alu_op_o,
                  dmem_req_o, dmem_we_o, rf_we_o, wb_sel_o, illegal_o};

    localparam logic [17:0] E_IREQ    = 18'h20000;
    localparam logic [17:0] E_IRWE    = 18'h10000;
    localparam logic [17:0] E_PCWE    = 18'h08000;
    localparam logic [17:0] E_PCS1    = 18'h02000;
    localparam logic [17:0] E_PCS2    = 18'h04000;
    localparam logic [17:0] E_A_PC    = 18'h00800;
    localparam logic [17:0] E_A_ZERO  = 18'h01000;
    localparam logic [17:0] E_BIMM    = 18'h00400;
    localparam logic [17:0] E_OP_SUB  = 18'h00040;
    localparam logic [17:0] E_OP_SLTU = 18'h00100;
    localparam logic [17:0] E_OP_XOR  = 18'h00140;
    localparam logic [17:0] E_OP_SRL  = 18'h00180;
    localparam logic [17:0] E_OP_SRA  = 18'h001C0;
    localparam logic [17:0] E_DREQ    = 18'h00020;
    localparam logic [17:0] E_DWE     = 18'h00010;
    localparam logic [17:0] E_RFWE    = 18'h00008;
    localparam logic [17:0] E_WB_LOAD = 18'h00002;
    localparam logic [17:0] E_WB_PC4  = 18'h00004;
    localparam logic [17:0] E_ILL     = 18'h00001;
    localparam logic [17:0] V_NONE    = 18'h00000;
    localparam logic [17:0] V_FETCH   = E_IREQ | E_IRWE | E_PCWE;

    rv_mc_ctrl #(.DATAWIDTH(32)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instrcode_i    (instrcode_i),
        .imem_ready_i   (imem_ready_i),
        .dmem_ready_i   (dmem_ready_i),
        .branch_taken_i (branch_taken_i),
        .imem_req_o     (imem_req_o),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .alu_a_sel_o    (alu_a_sel_o),
        .alu_b_sel_o    (alu_b_sel_o),
        .alu_op_o       (alu_op_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .rf_we_o        (rf_we_o),
        .wb_sel_o       (wb_sel_o),
        .illegal_o      (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        instrcode_i  = 32'h00500093;
        imem_ready_i = 1'b1;
        dmem_ready_i = 1'b1;
        #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if (obs !== V_NONE) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, V_NONE);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (obs !== V_FETCH) begin
            failures++;
            $display("FAIL reset_release_fetch got=%h exp=%h", obs, V_FETCH);
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_addi;
        logic [17:0] exp_v [5];
        exp_v = '{V_FETCH, V_NONE, E_BIMM, E_RFWE, V_FETCH};
        instrcode_i    = 32'h00500093;
        imem_ready_i   = 1'b1;
        dmem_ready_i   = 1'b1;
        branch_taken_i = 1'b0;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++;
            if (obs !== exp_v[c]) begin
                failures++;
                $display("FAIL addi_cycle%0d got=%h exp=%h", c, obs, exp_v[c]);
            end
            @(posedge clk_i);
            #1;
        end
        $display("test_addi done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_load_wait;
        logic [17:0] exp_v [9];
        logic        dr    [9];
        exp_v = '{V_FETCH, V_NONE, E_BIMM, E_BIMM | E_DREQ, E_BIMM | E_DREQ, E_BIMM | E_DREQ,
                  E_BIMM | E_DREQ, E_RFWE | E_WB_LOAD, V_FETCH};
        dr    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        instrcode_i  = 32'h0000A103;
        imem_ready_i = 1'b1;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            dmem_ready_i = dr[c];
            @(negedge clk_i);
            checks++;
            if (obs !== exp_v[c]) begin
                failures++;
                $display("FAIL lw_wait_cycle%0d got=%h exp=%h", c, obs, exp_v[c]);
            end
            @(posedge clk_i);
            #1;
        end
        dmem_ready_i = 1'b1;
        $display("test_load_wait done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_branch;
        logic [17:0] exp_v [4];
        for (int t = 0; t < 2; t++) begin
            branch_taken_i = (t == 0);
            exp_v = '{V_FETCH, V_NONE,
                      (t == 0) ? (E_PCWE | E_PCS1 | E_A_PC | E_BIMM) : (E_A_PC | E_BIMM),
                      V_FETCH};
            instrcode_i  = 32'h00208463;
            imem_ready_i = 1'b1;
            apply_reset();
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                checks++;
                if (obs !== exp_v[c]) begin
                    failures++;
                    $display("FAIL beq_taken%0d_cycle%0d got=%h exp=%h", 1 - t, c, obs, exp_v[c]);
                end
                @(posedge clk_i);
                #1;
            end
        end
        branch_taken_i = 1'b0;
        $display("test_branch done checks=%0d failures=%0d", checks, failures);
    endtask

    // Back-to-back four-cycle instructions: EXEC and WB vectors per instruction.
    task automatic test_back_to_back;
        logic [31:0] ins   [12];
        logic [17:0] ex_v  [12];
        logic [17:0] wb_v  [12];
        ins  = '{32'h00500093, 32'h40000033, 32'h40005033, 32'h00005033, 32'h40005013, 32'h40000013,
                 32'h00004013, 32'h00003033, 32'h000010B7, 32'h00001097, 32'h0000006F, 32'h000080E7};
        ex_v = '{E_BIMM, E_OP_SUB, E_OP_SRA, E_OP_SRL, E_BIMM | E_OP_SRA, E_BIMM,
                 E_BIMM | E_OP_XOR, E_OP_SLTU, E_A_ZERO | E_BIMM, E_A_PC | E_BIMM,
                 E_PCWE | E_PCS1 | E_A_PC | E_BIMM, E_PCWE | E_PCS2 | E_BIMM};
        wb_v = '{E_RFWE, E_RFWE, E_RFWE, E_RFWE, E_RFWE, E_RFWE, E_RFWE, E_RFWE, E_RFWE, E_RFWE,
                 E_RFWE | E_WB_PC4, E_RFWE | E_WB_PC4};
        imem_ready_i   = 1'b1;
        dmem_ready_i   = 1'b1;
        branch_taken_i = 1'b1;
        instrcode_i    = ins[0];
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            instrcode_i = ins[i];
            for (int c = 0; c < 4; c++) begin
                logic [17:0] e;
                e = (c == 0) ? V_FETCH : (c == 1) ? V_NONE : (c == 2) ? ex_v[i] : wb_v[i];
                @(negedge clk_i);
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL b2b_%h_cycle%0d got=%h exp=%h", ins[i], c, obs, e);
                end
                @(posedge clk_i);
                #1;
            end
        end
        branch_taken_i = 1'b0;
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_illegal;
        instrcode_i  = 32'hFFFFFFFF;
        imem_ready_i = 1'b1;
        dmem_ready_i = 1'b1;
        apply_reset();
        for (int c = 0; c < 24; c++) begin
            logic [17:0] e;
            e = (c == 0) ? V_FETCH : (c == 1) ? V_NONE : E_ILL;
            @(negedge clk_i);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL illegal_cycle%0d got=%h exp=%h", c, obs, e);
            end
            @(posedge clk_i);
            #1;
        end
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (obs !== V_NONE) begin
            failures++;
            $display("FAIL illegal_async_clear got=%h exp=%h", obs, V_NONE);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        instrcode_i = 32'h00500093;
        @(negedge clk_i);
        checks++;
        if (obs !== V_FETCH) begin
            failures++;
            $display("FAIL illegal_recover_fetch got=%h exp=%h", obs, V_FETCH);
        end
        $display("test_illegal done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_access;
        logic [17:0] exp_v [5];
        exp_v = '{V_FETCH, V_NONE, E_BIMM, E_BIMM | E_DREQ | E_DWE, E_BIMM | E_DREQ | E_DWE};
        instrcode_i  = 32'h0020A023;
        imem_ready_i = 1'b1;
        dmem_ready_i = 1'b0;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++;
            if (obs !== exp_v[c]) begin
                failures++;
                $display("FAIL sw_cycle%0d got=%h exp=%h", c, obs, exp_v[c]);
            end
            @(posedge clk_i);
            #1;
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (dmem_req_o !== 1'b0 || obs !== V_NONE) begin
            failures++;
            $display("FAIL sw_async_drop got=%h exp=%h", obs, V_NONE);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (obs !== V_FETCH) begin
            failures++;
            $display("FAIL sw_recover_fetch got=%h exp=%h", obs, V_FETCH);
        end
        dmem_ready_i = 1'b1;
        $display("test_reset_mid_access done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        rst_ni         = 1'b1;
        instrcode_i    = 32'h0;
        imem_ready_i   = 1'b0;
        dmem_ready_i   = 1'b0;
        branch_taken_i = 1'b0;
        test_reset();
        test_addi();
        test_load_wait();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_mc_ctrl.md
# rv_mc_ctrl

Multi-cycle control unit for the RV32I core datapath. It holds the instruction-sequencing FSM (fetch, decode, execute, memory, writeback) and decodes the instruction register. Each cycle it drives the select and enable lines for the PC, the instruction register, the ALU operand muxes, the memory ports and register-file writeback. It sits beside the immediate generator, which sees the same instruction register contents.

## Interface
- `DATAWIDTH`, 32, instruction width.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `instrcode_i` input DATAWIDTH: instruction register contents; valid from DECODE onward.
- `imem_ready_i` input 1: instruction memory returns data this cycle.
- `dmem_ready_i` input 1: data memory access completes this cycle.
- `branch_taken_i` input 1: comparator result for rs1/rs2 under funct3; valid in EXEC.
- `imem_req_o` output 1: instruction fetch request.
- `ir_we_o` output 1: load the instruction register and the old-PC register.
- `pc_we_o` output 1: PC write enable.
- `pc_sel_o` output 2: PC source. 0 = PC+4, 1 = ALU result, 2 = ALU result & ~1.
- `alu_a_sel_o` output 2: ALU operand A. 0 = rs1, 1 = old PC, 2 = zero.
- `alu_b_sel_o` output 1: ALU operand B. 0 = rs2, 1 = immediate.
- `alu_op_o` output 4: ALU operation code (package enum).
- `dmem_req_o` output 1: data memory request.
- `dmem_we_o` output 1: data memory write.
- `rf_we_o` output 1: register-file write enable.
- `wb_sel_o` output 2: writeback source. 0 = ALU, 1 = load data, 2 = old PC+4.
- `illegal_o` output 1: sticky illegal-instruction flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **FETCH**
  - `imem_req_o` is 1 every cycle.
  - On `imem_ready_i`: pulse `ir_we_o` and `pc_we_o` (`pc_sel_o` = 0), then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**: one cycle; opcode is `instrcode_i[6:0]`.
  - Supported opcodes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode goes to TRAP.
- **EXEC**
  - OP: A = rs1, B = rs2. alu_op from funct3, with funct7[5] selecting SUB/SRA. Next state WB.
  - OP-IMM: B = imm. funct7[5] is used only for SRAI. Next state WB.
  - LOAD/STORE: A = rs1, B = imm, op ADD. Next state MEM.
  - LUI: A = zero, B = imm, op ADD. Next state WB.
  - AUIPC: A = old PC, B = imm, op ADD. Next state WB.
  - BRANCH: A = old PC, B = imm, op ADD.
    - If `branch_taken_i`: `pc_we_o` = 1 with `pc_sel_o` = 1.
    - Next state FETCH.
  - JAL: as BRANCH, but the PC write is unconditional. Next state WB.
  - JALR: A = rs1, B = imm, `pc_sel_o` = 2, PC write unconditional. Next state WB.
- **MEM**
  - `dmem_req_o` is held at 1, with `dmem_we_o` = 1 for STORE.
  - ALU controls stay as in EXEC, so the address is stable.
  - On `dmem_ready_i`: LOAD goes to WB, STORE goes to FETCH.
- **WB**: `rf_we_o` = 1 for one cycle, then go to FETCH.
  - `wb_sel_o` = 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
- **TRAP**: `illegal_o` = 1; all enables and requests are 0; the FSM stays in TRAP until reset.
- In every state, outputs not listed above are 0.

## Timing
- Reset (asynchronous, any state, including mid-MEM):
  - state = FETCH.
  - All outputs are 0 except `imem_req_o`, which is 1 from the first cycle after `rst_ni` deasserts.
- Per-instruction cycles, with zero memory wait (ready=1 on the first request cycle):
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4.
  - BRANCH: 3.
  - STORE: 4.
  - LOAD: 5.
  - Each memory wait cycle adds 1.
- Requests are level signals and stay asserted until the ready input is seen. No new request is issued in the ready cycle.
- `ir_we_o`, `pc_we_o` and `rf_we_o` are single-cycle pulses.
- Ready inputs are ignored in states that do not request.
- Control outputs are a combinational function of state and `instrcode_i`. The next state is registered.

## Structure
- Shared package `rv_pkg` contains:
  - the state enum,
  - the opcode constants,
  - the `alu_op` enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND),
  - the `pc_sel`, `alu_a_sel` and `wb_sel` encodings.
- One sub-module, `rv_alu_dec`: combinational `alu_op` from opcode, funct3 and funct7[5]. The FSM lives in `rv_mc_ctrl`.

## Test plan
- **ADDI sequence.** Apply reset. Supply `instrcode_i` = 0x00500093 with ready=1. Required:
  - FETCH→DECODE→EXEC→WB→FETCH, 4 cycles.
  - `alu_b_sel_o` = 1 and `alu_op_o` = ADD in EXEC.
  - `rf_we_o` = 1 with `wb_sel_o` = 0 in WB.
- **Load with memory wait.** Instruction LW 0x0000A103, with `dmem_ready_i` held 0 for 3 cycles. Required:
  - `dmem_req_o` = 1 for 4 cycles with `dmem_we_o` = 0.
  - Then WB with `wb_sel_o` = 1.
  - Total 8 cycles.
- **Branch.** BEQ 0x00208463:
  - With `branch_taken_i` = 1: `pc_we_o` = 1 and `pc_sel_o` = 1 in EXEC, then FETCH (3 cycles).
  - With `branch_taken_i` = 0: no `pc_we_o` in EXEC.
- **JALR.** Instruction 0x000080E7. Required:
  - `pc_sel_o` = 2 and `pc_we_o` = 1 in EXEC.
  - `rf_we_o` = 1 with `wb_sel_o` = 2 in WB.
- **Illegal opcode.** Instruction 0xFFFFFFFF. Required:
  - TRAP is entered after DECODE, and `illegal_o` stays 1 for 20+ cycles.
  - Every request and enable stays 0.
  - `rst_ni` low clears `illegal_o` immediately.
- **Reset mid-access.** Assert `rst_ni` low during MEM of SW 0x0020A023. Required:
  - `dmem_req_o` drops in the same cycle, without waiting for a clock edge.
  - After release, `imem_req_o` = 1 from FETCH.
